// File: rtl/vme_rd_cmd_arbiter.sv
// ============================================================================
// vme_rd_cmd_arbiter
//
// Purpose:
//   Shares the single VME read command channel among NUM_CLIENTS tensor-load
//   command generators (inp, wgt, acc, uop). A round-robin arbiter picks one
//   requester, registers its command onto io_vmeCmd, and records the granted
//   client ID in an in-order FIFO. Returned read-data beats are steered back
//   to the client at the FIFO head. The FIFO pops on the last beat of each
//   command.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
//   edge where valid && ready are both 1. A producer holds valid and its
//   payload stable until the transfer. ready may depend combinationally on
//   valid. The one exception is io_req_ready, which is only offered in IDLE.
//
// Ports:
//   clock, reset           - sole clock, synchronous active-low reset
//   io_req_*               - per-client command request (addr/len/tag packed,
//                            client i in slice i)
//   io_vmeCmd_*            - registered command towards the VME read port
//   io_vmeData_*           - read-data beats returned by VME
//   io_rd_*                - beats routed to clients (valid one-hot, data and
//                            last broadcast)
//   io_err                 - sticky: a beat arrived with no command outstanding
//   io_stallCycles         - command back-pressure cycle count
//
// FSM state visibility: the FSM has two states and io_vmeCmd_valid is
//   exactly (state == SEND), so the state is observable on that port.
//
// Build option:
//   VME_RD_ARB_PERF_CNT_EN - when defined, io_stallCycles counts cycles with
//   io_vmeCmd_valid && !io_vmeCmd_ready (saturating). When undefined, the port
//   is tied to 0 and no counter is built.
//
// MAX_OUTST must be a power of two and at least 2.
// ============================================================================
module vme_rd_cmd_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int MAX_OUTST   = 8,
    parameter int DATA_W      = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CLIENTS-1:0]    io_req_valid,
    output logic [NUM_CLIENTS-1:0]    io_req_ready,
    input  logic [NUM_CLIENTS*32-1:0] io_req_addr,
    input  logic [NUM_CLIENTS*8-1:0]  io_req_len,
    input  logic [NUM_CLIENTS*21-1:0] io_req_tag,
    input  logic                      io_vmeCmd_ready,
    output logic                      io_vmeCmd_valid,
    output logic [31:0]               io_vmeCmd_bits_addr,
    output logic [7:0]                io_vmeCmd_bits_len,
    output logic [20:0]               io_vmeCmd_bits_tag,
    input  logic                      io_vmeData_valid,
    output logic                      io_vmeData_ready,
    input  logic [DATA_W-1:0]         io_vmeData_bits_data,
    input  logic                      io_vmeData_bits_last,
    output logic [NUM_CLIENTS-1:0]    io_rd_valid,
    input  logic [NUM_CLIENTS-1:0]    io_rd_ready,
    output logic [DATA_W-1:0]         io_rd_data,
    output logic                      io_rd_last,
    output logic                      io_err,
    output logic [31:0]               io_stallCycles
);

    localparam int ID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rrPtr;
    logic [ID_W-1:0]   cmdId;
    logic              errReg;

    // Outstanding-command ID FIFO
    logic [ID_W-1:0]   fifoMem [MAX_OUTST];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              fifoEmpty;
    logic              fifoFull;
    logic [ID_W-1:0]   headId;

    // Arbitration
    logic              grantFound;
    logic [ID_W-1:0]   grantId;
    logic              grant;
    logic [31:0]       selAddr;
    logic [7:0]        selLen;
    logic [20:0]       selTag;

    logic              push;
    logic              pop;
    logic              beatFire;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == CNT_W'(MAX_OUTST));
    assign headId    = fifoMem[rdPtr];

    // Round-robin search: first requester at or after (rrPtr+1) mod N.
    always_comb begin
        logic [ID_W-1:0] cand;
        grantFound = 1'b0;
        grantId    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            cand = ID_W'((int'(rrPtr) + k) % NUM_CLIENTS);
            if (!grantFound && io_req_valid[cand]) begin
                grantFound = 1'b1;
                grantId    = cand;
            end
        end
    end

    // Payload mux for the winning client.
    always_comb begin
        selAddr = '0;
        selLen  = '0;
        selTag  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grantId == ID_W'(i)) begin
                selAddr = io_req_addr[32*i +: 32];
                selLen  = io_req_len[8*i +: 8];
                selTag  = io_req_tag[21*i +: 21];
            end
        end
    end

    // Grant only in IDLE with room in the ID FIFO; reset suppresses it so
    // no client sees an acceptance that the reset edge would discard.
    assign grant        = reset && (state == IDLE) && grantFound && !fifoFull;
    assign io_req_ready = grant ? (NUM_CLIENTS'(1) << grantId) : '0;

    assign io_vmeCmd_valid = (state == SEND);

    assign push     = reset && (state == SEND) && io_vmeCmd_ready;
    assign beatFire = io_vmeData_valid && io_vmeData_ready;
    assign pop      = beatFire && io_vmeData_bits_last;

    // Data routing: beats belong to the oldest outstanding command.
    assign io_rd_valid      = (io_vmeData_valid && !fifoEmpty) ? (NUM_CLIENTS'(1) << headId) : '0;
    assign io_vmeData_ready = !fifoEmpty && io_rd_ready[headId];
    assign io_rd_data       = io_vmeData_bits_data;
    assign io_rd_last       = io_vmeData_bits_last;
    assign io_err           = errReg;

    // FSM, command output registers, FIFO pointers and error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state               <= IDLE;
            rrPtr               <= ID_W'(NUM_CLIENTS - 1);
            cmdId               <= '0;
            io_vmeCmd_bits_addr <= '0;
            io_vmeCmd_bits_len  <= '0;
            io_vmeCmd_bits_tag  <= '0;
            wrPtr               <= '0;
            rdPtr               <= '0;
            count               <= '0;
            errReg              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        io_vmeCmd_bits_addr <= selAddr;
                        io_vmeCmd_bits_len  <= selLen;
                        io_vmeCmd_bits_tag  <= selTag;
                        cmdId               <= grantId;
                        state               <= SEND;
                    end
                end
                SEND: begin
                    // Pointer advances only once the command is really issued.
                    if (io_vmeCmd_ready) begin
                        rrPtr <= cmdId;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (io_vmeData_valid && fifoEmpty) begin
                errReg <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= cmdId;
        end
    end

`ifdef VME_RD_ARB_PERF_CNT_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (io_vmeCmd_valid && !io_vmeCmd_ready && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign io_stallCycles = stallCnt;
`else
    assign io_stallCycles = '0;
`endif

endmodule

// File: tb/tb_vme_rd_cmd_arbiter.sv
`timescale 1ns/1ps
module tb_vme_rd_cmd_arbiter;

    localparam int NC = 4;
    localparam int DW = 64;

`ifdef VME_RD_ARB_PERF_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset;
    logic [NC-1:0]     req_valid;
    logic [NC-1:0]     req_ready;
    logic [NC*32-1:0]  req_addr;
    logic [NC*8-1:0]   req_len;
    logic [NC*21-1:0]  req_tag;
    logic              vme_cmd_ready;
    logic              vme_cmd_valid;
    logic [31:0]       vme_cmd_addr;
    logic [7:0]        vme_cmd_len;
    logic [20:0]       vme_cmd_tag;
    logic              vme_data_valid;
    logic              vme_data_ready;
    logic [DW-1:0]     vme_data;
    logic              vme_data_last;
    logic [NC-1:0]     rd_valid;
    logic [NC-1:0]     rd_ready;
    logic [DW-1:0]     rd_data;
    logic              rd_last;
    logic              err;
    logic [31:0]       stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    vme_rd_cmd_arbiter #(
        .NUM_CLIENTS (NC),
        .MAX_OUTST   (8),
        .DATA_W      (DW)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .io_req_valid         (req_valid),
        .io_req_ready         (req_ready),
        .io_req_addr          (req_addr),
        .io_req_len           (req_len),
        .io_req_tag           (req_tag),
        .io_vmeCmd_ready      (vme_cmd_ready),
        .io_vmeCmd_valid      (vme_cmd_valid),
        .io_vmeCmd_bits_addr  (vme_cmd_addr),
        .io_vmeCmd_bits_len   (vme_cmd_len),
        .io_vmeCmd_bits_tag   (vme_cmd_tag),
        .io_vmeData_valid     (vme_data_valid),
        .io_vmeData_ready     (vme_data_ready),
        .io_vmeData_bits_data (vme_data),
        .io_vmeData_bits_last (vme_data_last),
        .io_rd_valid          (rd_valid),
        .io_rd_ready          (rd_ready),
        .io_rd_data           (rd_data),
        .io_rd_last           (rd_last),
        .io_err               (err),
        .io_stallCycles       (stall_cycles)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int c, input logic [31:0] a, input logic [7:0] l, input logic [20:0] t);
        req_addr[32*c +: 32] = a;
        req_len[8*c +: 8]    = l;
        req_tag[21*c +: 21]  = t;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        req_valid      = '0;
        vme_cmd_ready  = 1'b0;
        vme_data_valid = 1'b0;
        vme_data_last  = 1'b0;
        vme_data       = '0;
        rd_ready       = '1;
        tick();
        tick();
        reset = 1'b1;
        settle();
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int exp_c;
        req_addr = '0;
        req_len  = '0;
        req_tag  = '0;

        // Reset state
        do_reset();
        reset = 1'b0;
        tick();
        chk("rst_cmd_valid", 64'(vme_cmd_valid), 64'd0);
        chk("rst_cmd_addr",  64'(vme_cmd_addr),  64'd0);
        chk("rst_req_ready", 64'(req_ready),     64'd0);
        chk("rst_data_rdy",  64'(vme_data_ready), 64'd0);
        chk("rst_rd_valid",  64'(rd_valid),      64'd0);
        chk("rst_err",       64'(err),           64'd0);
        chk("rst_stall",     64'(stall_cycles),  64'd0);
        reset = 1'b1;
        settle();

        // Round-robin: all clients request, order 0,1,2,3,0, grant every 2 cycles
        for (int i = 0; i < NC; i++) begin
            set_req(i, 32'h100 * (i + 1), 8'(i), 21'(16 + i));
        end
        req_valid     = 4'b1111;
        vme_cmd_ready = 1'b1;
        settle();
        for (int g = 0; g < 5; g++) begin
            exp_c = g % NC;
            chk("rr_grant", 64'(req_ready), 64'd1 << exp_c);
            tick();
            chk("rr_send_valid",   64'(vme_cmd_valid), 64'd1);
            chk("rr_send_noready", 64'(req_ready),     64'd0);
            chk("rr_send_tag",     64'(vme_cmd_tag),   64'(16 + exp_c));
            tick();
        end
        req_valid = '0;

        // Single client: client 2, addr 0x1000, len 3, tag 5
        do_reset();
        set_req(2, 32'h1000, 8'd3, 21'd5);
        req_valid     = 4'b0100;
        vme_cmd_ready = 1'b1;
        settle();
        chk("single_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        settle();
        chk("single_valid", 64'(vme_cmd_valid), 64'd1);
        chk("single_addr",  64'(vme_cmd_addr),  64'h1000);
        chk("single_len",   64'(vme_cmd_len),   64'd3);
        chk("single_tag",   64'(vme_cmd_tag),   64'd5);
        tick();
        chk("single_idle",  64'(vme_cmd_valid), 64'd0);
        vme_data_valid = 1'b1;
        vme_data_last  = 1'b1;
        vme_data       = 64'hDEAD_BEEF_0000_0001;
        settle();
        chk("single_rd_valid", 64'(rd_valid),       64'h4);
        chk("single_data_rdy", 64'(vme_data_ready), 64'd1);
        chk("single_rd_data",  64'(rd_data),        64'hDEAD_BEEF_0000_0001);
        chk("single_rd_last",  64'(rd_last),        64'd1);
        tick();
        chk("single_empty_rdy", 64'(vme_data_ready), 64'd0);
        chk("single_empty_rdv", 64'(rd_valid),       64'd0);
        vme_data_valid = 1'b0;
        settle();
        chk("single_no_err", 64'(err), 64'd0);

        // Back-pressure: 5 cycles of io_vmeCmd_ready=0 in SEND
        do_reset();
        set_req(0, 32'hA000, 8'd7, 21'h1F);
        req_valid     = 4'b1111;
        vme_cmd_ready = 1'b0;
        settle();
        chk("bp_grant", 64'(req_ready), 64'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",   64'(vme_cmd_valid), 64'd1);
            chk("bp_addr",    64'(vme_cmd_addr),  64'hA000);
            chk("bp_noready", 64'(req_ready),     64'd0);
            tick();
        end
        chk("bp_stall", 64'(stall_cycles), 64'(EXP_STALL));
        chk("bp_tag",   64'(vme_cmd_tag),   64'h1F);
        vme_cmd_ready = 1'b1;
        req_valid     = '0;
        settle();
        tick();
        chk("bp_done_valid", 64'(vme_cmd_valid), 64'd0);
        chk("bp_done_stall", 64'(stall_cycles),  64'(EXP_STALL));

        // Routing: client1 len=1 then client3 len=0, three beats
        do_reset();
        set_req(1, 32'hB000, 8'd1, 21'h11);
        set_req(3, 32'hC000, 8'd0, 21'h33);
        vme_cmd_ready = 1'b1;
        req_valid     = 4'b0010;
        settle();
        chk("rt_grant1", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        req_valid = 4'b1000;
        settle();
        chk("rt_grant3", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        tick();
        vme_data_valid = 1'b1;
        vme_data_last  = 1'b0;
        vme_data       = 64'h1;
        settle();
        chk("rt_beat1", 64'(rd_valid), 64'h2);
        tick();
        vme_data_last = 1'b1;
        vme_data      = 64'h2;
        settle();
        chk("rt_beat2",      64'(rd_valid), 64'h2);
        chk("rt_beat2_last", 64'(rd_last),  64'd1);
        tick();
        vme_data = 64'h3;
        rd_ready = 4'b0111;
        settle();
        chk("rt_beat3",        64'(rd_valid),       64'h8);
        chk("rt_beat3_data",   64'(rd_data),        64'h3);
        chk("rt_beat3_blocked", 64'(vme_data_ready), 64'd0);
        tick();
        rd_ready = '1;
        settle();
        chk("rt_beat3_rdy", 64'(vme_data_ready), 64'd1);
        tick();
        chk("rt_empty_rdv", 64'(rd_valid),       64'd0);
        chk("rt_empty_rdy", 64'(vme_data_ready), 64'd0);
        vme_data_valid = 1'b0;
        settle();
        chk("rt_no_err", 64'(err), 64'd0);

        // Full: 8 grants with no data, 9th blocked until a last-beat pop
        do_reset();
        req_valid     = 4'b1111;
        vme_cmd_ready = 1'b1;
        settle();
        for (int g = 0; g < 8; g++) begin
            chk("full_fill_grant", 64'(req_ready), 64'd1 << (g % NC));
            tick();
            tick();
        end
        chk("full_no_grant", 64'(req_ready), 64'd0);
        tick();
        chk("full_idle",      64'(vme_cmd_valid), 64'd0);
        chk("full_no_grant2", 64'(req_ready),     64'd0);
        vme_data_valid = 1'b1;
        vme_data_last  = 1'b1;
        settle();
        chk("full_head", 64'(rd_valid), 64'h1);
        tick();
        vme_data_valid = 1'b0;
        vme_data_last  = 1'b0;
        settle();
        chk("full_regrant", 64'(req_ready), 64'h1);
        tick();
        chk("full_send", 64'(vme_cmd_valid), 64'd1);
        req_valid = '0;

        // Error and reset
        do_reset();
        vme_data_valid = 1'b1;
        settle();
        chk("err_data_rdy", 64'(vme_data_ready), 64'd0);
        chk("err_rd_valid", 64'(rd_valid),       64'd0);
        tick();
        chk("err_set", 64'(err), 64'd1);
        vme_data_valid = 1'b0;
        tick();
        chk("err_sticky", 64'(err), 64'd1);
        set_req(2, 32'h2222, 8'd2, 21'h22);
        req_valid     = 4'b0100;
        vme_cmd_ready = 1'b0;
        settle();
        tick();
        req_valid = '0;
        settle();
        chk("err_in_send", 64'(vme_cmd_valid), 64'd1);
        reset    = 1'b0;
        vme_data = '0;
        tick();
        chk("mrst_cmd_valid", 64'(vme_cmd_valid),  64'd0);
        chk("mrst_cmd_addr",  64'(vme_cmd_addr),   64'd0);
        chk("mrst_cmd_len",   64'(vme_cmd_len),    64'd0);
        chk("mrst_cmd_tag",   64'(vme_cmd_tag),    64'd0);
        chk("mrst_err",       64'(err),            64'd0);
        chk("mrst_req_ready", 64'(req_ready),      64'd0);
        chk("mrst_rd_valid",  64'(rd_valid),       64'd0);
        chk("mrst_data_rdy",  64'(vme_data_ready), 64'd0);
        chk("mrst_stall",     64'(stall_cycles),   64'd0);
        chk("mrst_rd_data",   64'(rd_data),        64'd0);
        reset          = 1'b1;
        vme_data_valid = 1'b1;
        settle();
        chk("mrst_fifo_empty", 64'(vme_data_ready), 64'd0);
        vme_data_valid = 1'b0;
        tick();

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vme_rd_cmd_arbiter.md
Name: vme_rd_cmd_arbiter

Overview:
- Shares the single VME read command channel among NUM_CLIENTS tensor-load command generators (inp, wgt, acc, uop).
- Round-robin arbitration; the winning command is registered onto io_vmeCmd.
- Returned read-data beats are routed back to the issuing client, using an in-order FIFO of granted client IDs.
- Sits between the per-tensor command generators and the VME read port.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- MAX_OUTST, 8, depth of the outstanding-command ID FIFO (power of 2).
- DATA_W, 64, VME read data width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  reset; synchronous, active-low.
- io_req_valid  in  NUM_CLIENTS  per-client command valid.
- io_req_ready  out  NUM_CLIENTS  per-client command accepted (one-hot or zero).
- io_req_addr  in  NUM_CLIENTS*32  client i at bits [32i+31:32i].
- io_req_len  in  NUM_CLIENTS*8  beats-1, packed like addr.
- io_req_tag  in  NUM_CLIENTS*21  client tag, packed like addr.
- io_vmeCmd_ready  in  1  VME accepts command.
- io_vmeCmd_valid  out  1  command valid.
- io_vmeCmd_bits_addr  out  32  granted address.
- io_vmeCmd_bits_len  out  8  granted length.
- io_vmeCmd_bits_tag  out  21  granted tag.
- io_vmeData_valid  in  1  read beat valid.
- io_vmeData_ready  out  1  read beat accepted.
- io_vmeData_bits_data  in  DATA_W  beat data.
- io_vmeData_bits_last  in  1  last beat of a command.
- io_rd_valid  out  NUM_CLIENTS  beat valid, routed to the owning client.
- io_rd_ready  in  NUM_CLIENTS  client accepts beat.
- io_rd_data  out  DATA_W  beat data, broadcast to all clients.
- io_rd_last  out  1  broadcast last flag.
- io_err  out  1  sticky: beat arrived with no command outstanding.
- io_stallCycles  out  32  command back-pressure count (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0; state IDLE; rr pointer = NUM_CLIENTS-1; FIFO empty; io_err=0. Reset mid-transfer drops all pending commands and in-flight IDs without completing them.
- FSM IDLE:
  - When any io_req_valid is set and the FIFO is not full, select the first requesting client at or after (ptr+1) mod NUM_CLIENTS.
  - Assert io_req_ready[winner] combinationally in that cycle (ready is gated on FIFO not full).
  - Latch the winner's addr/len/tag and ID into output registers; go to SEND.
- FSM SEND:
  - io_vmeCmd_valid=1; bits stay stable.
  - On io_vmeCmd_ready: push winner ID into the FIFO, set ptr=winner, go to IDLE.
  - No re-arbitration and no bit change while in SEND.
- Timing: latency is req accept to io_vmeCmd_valid = 1 cycle. Maximum throughput is 1 command per 2 cycles. io_req_ready is never asserted while in SEND.
- FIFO full (MAX_OUTST entries): no grant. io_req_ready stays 0 and the FSM stays in IDLE.
- Data routing:
  - head = FIFO head ID.
  - io_rd_valid[head] = io_vmeData_valid && !empty; other bits 0.
  - io_vmeData_ready = !empty && io_rd_ready[head].
  - io_rd_data and io_rd_last are driven combinationally from the io_vmeData inputs.
  - A beat fires when io_vmeData_valid && io_vmeData_ready. The FIFO pops on a fired beat with last=1.
- Simultaneous push and pop in the same cycle: occupancy unchanged. Push into a full FIFO cannot occur because the grant is blocked.
- FIFO empty while io_vmeData_valid=1: io_vmeData_ready=0 and io_err is set (sticky until reset). The beat is not consumed.
- Arithmetic: FIFO pointers are log2(MAX_OUTST) bits and wrap modulo depth. Occupancy counter is log2(MAX_OUTST)+1 bits.

Optional Feature:
- Macro: VME_RD_ARB_PERF_CNT_EN.
- Defined: io_stallCycles counts cycles with io_vmeCmd_valid && !io_vmeCmd_ready. It saturates at 0xFFFFFFFF and is cleared by reset.
- Undefined: io_stallCycles is tied to 0 and no counter register is built. The port list is identical in both builds.

Test Plan:
- Single client: client 2 requests addr=0x1000, len=3, tag=5 with io_vmeCmd_ready=1 -> io_req_ready[2] pulses at t; at t+1 io_vmeCmd_valid=1 with addr=0x1000, len=3, tag=5; one FIFO entry.
- Round-robin: all 4 clients hold valid, io_vmeCmd_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles.
- Back-pressure: io_vmeCmd_ready=0 for 5 cycles while in SEND -> bits stable, no io_req_ready pulses, io_stallCycles=5 (macro on) or 0 (macro off).
- Routing: issue client1 len=1, then client3 len=0; return 3 beats with last on beats 2 and 3 -> io_rd_valid=0b0010, 0b0010, 0b1000; FIFO empty afterwards.
- Full: MAX_OUTST=8 grants with no data returned -> 9th request is not granted; after one last-beat pop, it is granted next cycle.
- Error and reset: io_vmeData_valid=1 with the FIFO empty -> io_err=1, io_vmeData_ready=0. Then reset=0 for one cycle while in SEND -> all outputs 0 and FIFO empty.
